// File: rtl/loopback_fifo.sv
// Loopback FIFO between the usb_cdc OUT and IN byte streams with echo, case-flip, discard and
// (when LOOPBACK_GEN_EN is defined) counting-generator modes, plus a stretched activity flag.
module loopback_fifo #(
    parameter int DEPTH    = 16,
    parameter int ACT_BITS = 20
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [1:0]               mode_i,
    input  logic                     flush_i,
    input  logic [7:0]               out_data_i,
    input  logic                     out_valid_i,
    output logic                     out_ready_o,
    output logic [7:0]               in_data_o,
    output logic                     in_valid_o,
    input  logic                     in_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     activity_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);

    typedef enum logic [1:0] {
        MODE_ECHO    = 2'b00,
        MODE_FLIP    = 2'b01,
        MODE_DISCARD = 2'b10,
        MODE_GEN     = 2'b11
    } mode_t;

    mode_t               mode;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [7:0]          mem [DEPTH];
    logic                full;
    logic                empty;
    logic                accept;
    logic                emit;
    logic                wr_en;
    logic                wr_go;
    logic                rd_go;
    logic                limit;
    logic [7:0]          wr_byte;
    logic [PW-1:0]       next_level;
    logic                ready_d;
    logic [ACT_BITS-1:0] act_cnt;

`ifdef LOOPBACK_GEN_EN
    logic [7:0]          gen_cnt;
`endif

    function automatic logic [7:0] flip_case(input logic [7:0] b);
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) begin
            return b ^ 8'h20;
        end
        return b;
    endfunction

    assign mode       = mode_t'(mode_i);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign level_o    = wr_ptr - rd_ptr;
    assign in_valid_o = ~empty;
    assign in_data_o  = mem[rd_ptr[AW-1:0]];
    assign accept     = out_valid_i & out_ready_o;
    assign emit       = in_valid_o & in_ready_i;
    assign activity_o = (act_cnt != '0);

    // Transforms happen at write time; limit selects whether out_ready tracks FIFO space.
    always_comb begin
        wr_en   = accept & ~full;
        wr_byte = out_data_i;
        limit   = 1'b1;
        case (mode)
            MODE_FLIP: begin
                wr_byte = flip_case(out_data_i);
            end
            MODE_DISCARD: begin
                wr_en = 1'b0;
                limit = 1'b0;
            end
`ifdef LOOPBACK_GEN_EN
            MODE_GEN: begin
                wr_en   = ~full;
                wr_byte = gen_cnt;
                limit   = 1'b0;
            end
`endif
            default: begin
                wr_en   = accept & ~full;
                wr_byte = out_data_i;
                limit   = 1'b1;
            end
        endcase
    end

    // Flush wins over any handshake in the same cycle.
    always_comb begin
        wr_go      = wr_en & ~flush_i;
        rd_go      = emit & ~flush_i;
        next_level = level_o + PW'(wr_go) - PW'(rd_go);
        ready_d    = 1'b0;
        if (!flush_i) begin
            ready_d = limit ? (next_level < DEPTH_L) : 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_ready_o <= 1'b0;
        end else if (flush_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_ready_o <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + PW'(wr_go);
            rd_ptr      <= rd_ptr + PW'(rd_go);
            out_ready_o <= ready_d;
        end
    end

    // Storage is deliberately left unreset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (wr_go) begin
            mem[wr_ptr[AW-1:0]] <= wr_byte;
        end
    end

`ifdef LOOPBACK_GEN_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            gen_cnt <= '0;
        end else if (flush_i) begin
            gen_cnt <= '0;
        end else if (wr_go && mode == MODE_GEN) begin
            gen_cnt <= gen_cnt + 8'd1;
        end
    end
`endif

    // Transfers during a flush cycle do not retrigger the LED stretch.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            act_cnt <= '0;
        end else if ((accept | emit) & ~flush_i) begin
            act_cnt <= '1;
        end else if (act_cnt != '0) begin
            act_cnt <= act_cnt - ACT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_loopback_fifo.sv
// Randomized self-checking bench for loopback_fifo (DEPTH=4) against a queue-based reference model;
// generator expectations follow LOOPBACK_GEN_EN when it is defined.
module tb_loopback_fifo;

    localparam int DEPTH    = 4;
    localparam int ACT_BITS = 3;
    localparam int ACT_MAX  = (1 << ACT_BITS) - 1;

    logic       clk;
    logic       rstn;
    logic [1:0] mode;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] level;
    logic       activity;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic [7:0] emitted[$];
    bit         m_ready;
    int         m_gen;
    int         m_act;

    logic [13:0] obs;

    loopback_fifo #(.DEPTH(DEPTH), .ACT_BITS(ACT_BITS)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .mode_i      (mode),
        .flush_i     (flush),
        .out_data_i  (out_data),
        .out_valid_i (out_valid),
        .out_ready_o (out_ready),
        .in_data_o   (in_data),
        .in_valid_o  (in_valid),
        .in_ready_i  (in_ready),
        .level_o     (level),
        .activity_o  (activity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {out_ready, in_valid, (in_valid ? in_data : 8'h00), level, activity};

    function automatic logic [7:0] case_swap(input logic [7:0] b);
        if (b >= "A" && b <= "Z") return b + 8'd32;
        if (b >= "a" && b <= "z") return b - 8'd32;
        return b;
    endfunction

    function automatic logic [13:0] expected_obs();
        logic [7:0] head;
        head = 8'h00;
        if (mq.size() != 0) head = mq[0];
        return {m_ready, (mq.size() != 0), head, 3'(mq.size()), (m_act != 0)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ready = 1'b0;
        m_gen   = 0;
        m_act   = 0;
    endtask

    // Advance the reference model by one clock using the inputs currently driven, then step the DUT.
    task automatic tick();
        bit acc;
        bit emt;
        int pre;
        int eff_mode;
        acc      = out_valid && m_ready;
        emt      = in_ready && (mq.size() != 0);
        eff_mode = int'(mode);
`ifndef LOOPBACK_GEN_EN
        if (eff_mode == 3) eff_mode = 0;
`endif
        if (flush) begin
            mq.delete();
            m_gen   = 0;
            m_ready = 1'b0;
            if (m_act > 0) m_act--;
        end else begin
            pre = mq.size();
            if (emt) emitted.push_back(mq.pop_front());
            if (eff_mode == 0 && acc && pre < DEPTH) mq.push_back(out_data);
            if (eff_mode == 1 && acc && pre < DEPTH) mq.push_back(case_swap(out_data));
            if (eff_mode == 3 && pre < DEPTH) begin
                mq.push_back(8'(m_gen));
                m_gen = (m_gen + 1) % 256;
            end
            m_ready = (eff_mode <= 1) ? (mq.size() < DEPTH) : 1'b1;
            if (acc || emt) m_act = ACT_MAX;
            else if (m_act > 0) m_act--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic f, input logic v,
                                 input logic [7:0] d, input logic r);
        mode      = m;
        flush     = f;
        out_valid = v;
        out_data  = d;
        in_ready  = r;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_ready got=%b want=0", out_ready);
        end
        checks++;
        if (in_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_valid got=%b want=0", in_valid);
        end
        checks++;
        if (level !== 3'd0) begin
            failures++;
            $display("FAIL reset_level got=%0d want=0", level);
        end
        checks++;
        if (activity !== 1'b0) begin
            failures++;
            $display("FAIL reset_activity got=%b want=0", activity);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (out_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b want=1", out_ready);
        end
        checks++;
        if (obs !== expected_obs()) begin
            failures++;
            $display("FAIL reset_release_state got=%h want=%h", obs, expected_obs());
        end
    endtask

    task automatic test_echo();
        logic [7:0] bytes [3];
        bytes = '{8'h31, 8'h32, 8'h33};
        emitted.delete();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b1, bytes[i], 1'b1);
            tick();
            checks++;
            if (in_valid !== 1'b1 || in_data !== bytes[i]) begin
                failures++;
                $display("FAIL echo_visible_next_cycle i=%0d got=%b/%h want=1/%h", i, in_valid, in_data, bytes[i]);
            end
        end
        applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== expected_obs()) begin
                failures++;
                $display("FAIL echo_state i=%0d got=%h want=%h", i, obs, expected_obs());
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (emitted.size() <= i || emitted[i] !== bytes[i]) begin
                failures++;
                $display("FAIL echo_order i=%0d got=%h want=%h", i, (emitted.size() > i) ? emitted[i] : 8'hxx, bytes[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int sent;
        int cycles;
        sent = 0;
        cycles = 0;
        emitted.delete();
        while (sent < 4 && cycles < 20) begin
            bit acc;
            applyStimulus(2'b00, 1'b0, 1'b1, 8'h50 + 8'(sent), 1'b0);
            acc = m_ready;
            tick();
            cycles++;
            if (acc) sent++;
        end
        applyStimulus(2'b00, 1'b0, 1'b1, 8'h54, 1'b0);
        tick();
        checks++;
        if (level !== 3'd4 || out_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full level=%0d ready=%b want level=4 ready=0", level, out_ready);
        end
        in_ready = 1'b1;
        cycles = 0;
        while (emitted.size() < 5 && cycles < 20) begin
            if (mq.size() == 0 && emitted.size() == 4) out_valid = 1'b0;
            if (m_ready && out_valid) begin
                tick();
                out_valid = 1'b0;
            end else begin
                tick();
            end
            cycles++;
            checks++;
            if (obs !== expected_obs()) begin
                failures++;
                $display("FAIL bp_drain_state cycle=%0d got=%h want=%h", cycles, obs, expected_obs());
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (emitted.size() <= i || emitted[i] !== 8'h50 + 8'(i)) begin
                failures++;
                $display("FAIL bp_order i=%0d got=%h want=%h", i, (emitted.size() > i) ? emitted[i] : 8'hxx, 8'h50 + 8'(i));
            end
        end
    endtask

    task automatic test_case_flip();
        logic [7:0] src [4];
        logic [7:0] want [4];
        src  = '{8'h41, 8'h7A, 8'h5B, 8'h40};
        want = '{8'h61, 8'h5A, 8'h5B, 8'h40};
        emitted.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b01, 1'b0, 1'b1, src[i], 1'b1);
            tick();
        end
        applyStimulus(2'b01, 1'b0, 1'b0, 8'h00, 1'b1);
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (emitted.size() <= i || emitted[i] !== want[i]) begin
                failures++;
                $display("FAIL flip_vector i=%0d got=%h want=%h", i, (emitted.size() > i) ? emitted[i] : 8'hxx, want[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'b01, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            tick();
            checks++;
            if (obs !== expected_obs()) begin
                failures++;
                $display("FAIL flip_random i=%0d got=%h want=%h", i, obs, expected_obs());
            end
        end
    endtask

    task automatic test_flush();
        applyStimulus(2'b00, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
            if (!m_ready) tick();
            tick();
        end
        applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (level !== 3'd3) begin
            failures++;
            $display("FAIL flush_setup_level got=%0d want=3", level);
        end
        applyStimulus(2'b00, 1'b1, 1'b1, 8'hEE, 1'b1);
        tick();
        checks++;
        if (level !== 3'd0 || out_ready !== 1'b0 || in_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear level=%0d ready=%b valid=%b want 0/0/0", level, out_ready, in_valid);
        end
        applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        checks++;
        if (obs !== expected_obs() || in_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_after got=%h want=%h", obs, expected_obs());
        end
    endtask

    task automatic test_activity();
        applyStimulus(2'b00, 1'b0, 1'b1, 8'h77, 1'b1);
        tick();
        applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (obs !== expected_obs()) begin
                failures++;
                $display("FAIL activity_state i=%0d got=%h want=%h", i, obs, expected_obs());
            end
        end
        checks++;
        if (activity !== 1'b0) begin
            failures++;
            $display("FAIL activity_expired got=%b want=0", activity);
        end
    endtask

    task automatic test_generator();
        int cycles;
        logic [7:0] gdata;
        applyStimulus(2'b11, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        emitted.delete();
        gdata = 8'h00;
        cycles = 0;
        while (emitted.size() < 300 && cycles < 1000) begin
            bit acc;
            applyStimulus(2'b11, 1'b0, 1'b1, gdata, 1'b1);
            acc = m_ready;
            tick();
            cycles++;
            if (acc) gdata = gdata + 8'd1;
            checks++;
            if (obs !== expected_obs()) begin
                failures++;
                $display("FAIL gen_state cycle=%0d got=%h want=%h", cycles, obs, expected_obs());
            end
        end
        checks++;
        if (emitted.size() < 300) begin
            failures++;
            $display("FAIL gen_timeout got=%0d bytes want=300", emitted.size());
        end
        for (int i = 0; i < 300 && i < emitted.size(); i++) begin
            checks++;
            if (emitted[i] !== 8'(i % 256)) begin
                failures++;
                $display("FAIL gen_sequence i=%0d got=%h want=%h", i, emitted[i], 8'(i % 256));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0),
                          1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
            tick();
            checks++;
            if (obs !== expected_obs()) begin
                failures++;
                $display("FAIL random_state i=%0d mode=%0d got=%h want=%h", i, mode, obs, expected_obs());
            end
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(2'b00, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
            if (!m_ready) tick();
            tick();
        end
        applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (level !== 3'd2) begin
            failures++;
            $display("FAIL rstmid_setup_level got=%0d want=2", level);
        end
        rstn = 1'b0;
        model_reset();
        #2;
        checks++;
        if (in_valid !== 1'b0 || activity !== 1'b0 || level !== 3'd0 || out_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_immediate valid=%b act=%b level=%0d ready=%b want 0/0/0/0", in_valid, activity, level, out_ready);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        checks++;
        if (out_ready !== 1'b1 || in_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_release ready=%b valid=%b want 1/0", out_ready, in_valid);
        end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_backpressure();
        test_case_flip();
        test_flush();
        test_activity();
        test_generator();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/loopback_fifo.md
LOOPBACK_FIFO -- requirements
Module: loopback_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter ACT_BITS, default 20, meaning activity-stretch counter width.
REQ-003 SHALL have port clk_i  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn_i  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port mode_i  input  2  meaning 00 echo, 01 case-flip, 10 discard, 11 generator.
REQ-006 SHALL have port flush_i  input  1  meaning synchronous FIFO clear.
REQ-007 SHALL have port out_data_i  input  8  meaning byte from usb_cdc OUT stream.
REQ-008 SHALL have port out_valid_i  input  1  meaning out_data_i valid.
REQ-009 SHALL have port out_ready_o  output  1  meaning block accepts out_data_i.
REQ-010 SHALL have port in_data_o  output  8  meaning byte to usb_cdc IN stream.
REQ-011 SHALL have port in_valid_o  output  1  meaning in_data_o valid.
REQ-012 SHALL have port in_ready_i  input  1  meaning usb_cdc accepts in_data_o.
REQ-013 SHALL have port level_o  output  clog2(DEPTH)+1  meaning current FIFO occupancy.
REQ-014 SHALL have port activity_o  output  1  meaning stretched transfer indicator for LED.

Function
REQ-015 SHALL accept a byte when out_valid_i & out_ready_o, and emit a byte when in_valid_o & in_ready_i.
REQ-016 SHALL implement a first-word-fall-through FIFO; in_valid_o = (level_o != 0); in_data_o = entry at read pointer.
REQ-017 SHALL make a byte written in cycle N visible on in_valid_o/in_data_o in cycle N+1.
REQ-018 SHALL register out_ready_o: in modes 00/01 loaded each cycle with (next level < DEPTH) & ~flush_i; in modes 10/11 loaded with ~flush_i.
REQ-019 SHALL use read/write pointers of clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full when MSBs differ and low bits equal.
REQ-020 SHALL, on simultaneous write and read, keep level_o unchanged and preserve byte order.
REQ-021 SHALL never write when full nor read when empty, regardless of handshake inputs.
REQ-022 SHALL, in mode 00, store out_data_i unchanged.
REQ-023 SHALL, in mode 01, invert bit 5 of bytes in 0x41-0x5A and 0x61-0x7A; other bytes unchanged.
REQ-024 SHALL, in mode 10, accept and drop every input byte without writing the FIFO.
REQ-025 SHALL, in mode 11, drop input bytes and write an 8-bit generator value every cycle the FIFO is not full, then increment it (0xFF wraps to 0x00).
REQ-026 SHALL apply transforms at write time; mode_i changes affect only subsequent writes; stored bytes are kept.
REQ-027 SHALL, when flush_i=1, zero both pointers and the generator counter next cycle; flush wins over simultaneous write/read (no byte accepted or emitted that cycle counts).
REQ-028 SHALL reload the activity counter to all-ones on any accepted input or emitted output byte, otherwise decrement to 0; activity_o = (counter != 0).

Reset
REQ-029 SHALL, while rstn_i=0, force pointers, level_o, generator and activity counters to 0, out_ready_o=0, in_valid_o=0, activity_o=0.
REQ-030 SHALL raise out_ready_o on the first clk_i edge after rstn_i deasserts (flush_i=0).
REQ-031 SHALL, on reset mid-transfer, discard all FIFO contents; memory array need not be reset.

Configuration
REQ-032 SHALL compile mode 11 only when macro LOOPBACK_GEN_EN is defined; without it the generator counter is absent and mode 11 behaves exactly as mode 00.

Verification
REQ-033 DEPTH=4, mode 00, write 0x31,0x32,0x33 with in_ready_i=1 -> same bytes out in order, each one cycle after acceptance.
REQ-034 DEPTH=4, in_ready_i=0, write 5 bytes -> out_ready_o low after 4th, level_o=4; raise in_ready_i -> 4 bytes out, 5th accepted after space frees.
REQ-035 mode 01, write 0x41,0x7A,0x5B,0x40 -> out 0x61,0x5A,0x5B,0x40.
REQ-036 mode 11 (LOOPBACK_GEN_EN), in_ready_i=1 for 300 accepted bytes -> 0x00..0xFF then 0x00..0x2B; without macro -> echo.
REQ-037 level_o=3, assert flush_i with out_valid_i=1 -> level_o=0 next cycle, input byte dropped, out_ready_o low that cycle.
REQ-038 rstn_i pulsed low with level_o=2 -> in_valid_o=0, activity_o=0 immediately; out_ready_o=1 one edge after release.
